// File: rtl/countdown_timer_pkg.sv
// ---------------------------------------------------------------------------
// countdown_timer_pkg
// Shared timer definitions used by the countdown timer and its bus interface.
//   CNT_W_DEF : default width of the count and load value
//   state_e   : timer state encoding (IDLE=0, RUN=1, HOLD=2)
// ---------------------------------------------------------------------------
package countdown_timer_pkg;

   localparam int CNT_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// ---------------------------------------------------------------------------
// countdown_timer_if
// Control/status bundle of the countdown timer.
//   load, load_val : load a new count (and reload value), forces IDLE
//   start, stop    : begin/resume and pause counting
//   tick           : one-cycle count-enable pulse per step
//   cnt, busy      : registered count and RUN indicator
//   done           : registered one-cycle pulse after the terminal tick
//   bout           : combinational borrow, cascades into the next stage's tick
// Modports: master drives the controls, slave is the timer itself.
// ---------------------------------------------------------------------------
interface countdown_timer_if #(
   parameter int CNT_W = countdown_timer_pkg::CNT_W_DEF
);

   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             start;
   logic             stop;
   logic             tick;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic             done;
   logic             bout;

   modport master (
      output load, load_val, start, stop, tick,
      input  cnt, busy, done, bout
   );

   modport slave (
      input  load, load_val, start, stop, tick,
      output cnt, busy, done, bout
   );

endinterface

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
// Loadable down-counter stepped by an external tick pulse. Counts the loaded
// value down to zero, flags the last step with a combinational borrow (bout)
// and a registered one-cycle done pulse. Several instances cascade by feeding
// bout into the next instance's tick.
//
// Parameters
//   CNT_W    : width of count and load value
//   RST_VAL  : count and reload value after reset
// Ports
//   clk      : clock, rising edge
//   rstn     : asynchronous reset, active-low
//   bus      : countdown_timer_if.slave (load/start/stop/tick in,
//              cnt/busy/done/bout out)
// Build option
//   AUTO_RELOAD_EN : when defined, the terminal tick reloads the count from
//                    the reload register and keeps running (periodic divider);
//                    a reload value of zero still returns to IDLE. When
//                    undefined the timer is one-shot.
// ---------------------------------------------------------------------------
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int RST_VAL = 0
) (
   input  logic               clk,
   input  logic               rstn,
   countdown_timer_if.slave   bus
);

`ifdef AUTO_RELOAD_EN
   localparam bit AUTO_RELOAD = 1'b1;
`else
   localparam bit AUTO_RELOAD = 1'b0;
`endif

   localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RST_VAL);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] reload_q;
   logic             busy_q;
   logic             done_q;

   logic [CNT_W-1:0] cnt_dec_d;
   logic             cnt_is_one;
   logic             cnt_is_zero;
   logic             reload_ok;

   assign cnt_dec_d   = cnt_q - ONE;
   assign cnt_is_one  = (cnt_q == ONE);
   assign cnt_is_zero = (cnt_q == '0);
   // A zero reload would restart a period of length zero; treat it as one-shot.
   assign reload_ok   = AUTO_RELOAD && (reload_q != '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         cnt_q    <= RST_CNT;
         reload_q <= RST_CNT;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.load) begin
            cnt_q    <= bus.load_val;
            reload_q <= bus.load_val;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  // A zero count has nothing to run; stop beats start.
                  if (bus.start && !bus.stop && !cnt_is_zero) begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end
               end
               RUN: begin
                  if (bus.stop) begin
                     state_q <= HOLD;
                     busy_q  <= 1'b0;
                  end else if (bus.tick) begin
                     if (cnt_is_one) begin
                        done_q <= 1'b1;
                        if (reload_ok) begin
                           cnt_q <= reload_q;
                        end else begin
                           cnt_q   <= '0;
                           state_q <= IDLE;
                           busy_q  <= 1'b0;
                        end
                     end else if (!cnt_is_zero) begin
                        cnt_q <= cnt_dec_d;
                     end else begin
                        // Unreachable in normal use; never wrap below zero.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end
                  end
               end
               HOLD: begin
                  if (bus.start && !bus.stop) begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.cnt  = cnt_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   // Same-cycle borrow so a cascaded stage steps on the same edge.
   assign bus.bout = (state_q == RUN) && bus.tick && cnt_is_one;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

`ifdef AUTO_RELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic clk;
   logic rstn;

   countdown_timer_if #(.CNT_W(4)) tif ();

   countdown_timer #(.CNT_W(4), .RST_VAL(0)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (tif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      nm;
      logic [3:0] cnt;
      logic       busy;
      logic       done;
      logic       bout;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endfunction

   // Drive one cycle of inputs at the falling edge and queue its expected result:
   // bout before the next rising edge, cnt/busy/done after it.
   task automatic st(input string nm, input logic l, input logic [3:0] lv,
                     input logic s, input logic p, input logic t,
                     input logic [3:0] ec, input logic eb, input logic ed, input logic ebo);
      exp_t e;
      @(negedge clk);
      tif.load = l; tif.load_val = lv; tif.start = s; tif.stop = p; tif.tick = t;
      e.nm = nm; e.cnt = ec; e.busy = eb; e.done = ed; e.bout = ebo;
      q.push_back(e);
   endtask

   task automatic idle_inputs();
      tif.load = 1'b0; tif.load_val = 4'd0; tif.start = 1'b0; tif.stop = 1'b0; tif.tick = 1'b0;
   endtask

   // Monitor: compare whenever a queued cycle is presented.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk({e.nm, ".bout"}, 32'(tif.bout), 32'(e.bout));
            @(posedge clk);
            #1;
            chk({e.nm, ".cnt"},  32'(tif.cnt),  32'(e.cnt));
            chk({e.nm, ".busy"}, 32'(tif.busy), 32'(e.busy));
            chk({e.nm, ".done"}, 32'(tif.done), 32'(e.done));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      idle_inputs();
      rstn = 1'b0;
      #1;
      chk("rst.cnt",  32'(tif.cnt),  32'd0);
      chk("rst.busy", 32'(tif.busy), 32'd0);
      chk("rst.done", 32'(tif.done), 32'd0);
      chk("rst.bout", 32'(tif.bout), 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // Basic one-shot count 3,2,1,0
      st("t2_load",  1, 4'd3, 0, 0, 0, 4'd3, 0, 0, 0);
      st("t2_start", 0, 4'd0, 1, 0, 0, 4'd3, 1, 0, 0);
      st("t2_tick1", 0, 4'd0, 0, 0, 1, 4'd2, 1, 0, 0);
      st("t2_tick2", 0, 4'd0, 0, 0, 1, 4'd1, 1, 0, 0);
      st("t2_tick3", 0, 4'd0, 0, 0, 1, AR ? 4'd3 : 4'd0, AR, 1, 1);
      st("t2_after", 0, 4'd0, 0, 0, 0, AR ? 4'd3 : 4'd0, AR, 0, 0);

      // Pause/resume, stop beats start and tick
      st("t3_load",   1, 4'd4, 0, 0, 0, 4'd4, 0, 0, 0);
      st("t3_start",  0, 4'd0, 1, 0, 0, 4'd4, 1, 0, 0);
      st("t3_tick",   0, 4'd0, 0, 0, 1, 4'd3, 1, 0, 0);
      st("t3_stoptk", 0, 4'd0, 0, 1, 1, 4'd3, 0, 0, 0);
      st("t3_htick1", 0, 4'd0, 0, 0, 1, 4'd3, 0, 0, 0);
      st("t3_htick2", 0, 4'd0, 0, 0, 1, 4'd3, 0, 0, 0);
      st("t3_resume", 0, 4'd0, 1, 0, 0, 4'd3, 1, 0, 0);
      st("t3_tick2",  0, 4'd0, 0, 0, 1, 4'd2, 1, 0, 0);
      st("t3_stop",   0, 4'd0, 0, 1, 0, 4'd2, 0, 0, 0);
      st("t3_ststp",  0, 4'd0, 1, 1, 0, 4'd2, 0, 0, 0);
      st("t3_start2", 0, 4'd0, 1, 0, 0, 4'd2, 1, 0, 0);
      st("t3_start3", 0, 4'd0, 1, 0, 0, 4'd2, 1, 0, 0);
      st("t3_notick", 0, 4'd0, 0, 0, 0, 4'd2, 1, 0, 0);
      st("t3_tick3",  0, 4'd0, 0, 0, 1, 4'd1, 1, 0, 0);
      st("t3_stplast",0, 4'd0, 0, 1, 1, 4'd1, 0, 0, 1);
      st("t3_htick3", 0, 4'd0, 0, 0, 1, 4'd1, 0, 0, 0);
      st("t3_start4", 0, 4'd0, 1, 0, 0, 4'd1, 1, 0, 0);
      st("t3_term",   0, 4'd0, 0, 0, 1, AR ? 4'd4 : 4'd0, AR, 1, 1);

      // Zero count cannot start; load wins over start/tick
      st("t4_load0",  1, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
      st("t4_start0", 0, 4'd0, 1, 0, 0, 4'd0, 0, 0, 0);
      st("t4_ldsttk", 1, 4'd2, 1, 0, 1, 4'd2, 0, 0, 0);
      st("t4_sttk",   0, 4'd0, 1, 0, 1, 4'd2, 1, 0, 0);
      st("t4_ldrun",  1, 4'd7, 0, 0, 1, 4'd7, 0, 0, 0);
      st("t4_start",  0, 4'd0, 1, 0, 0, 4'd7, 1, 0, 0);
      st("t4_load1",  1, 4'd1, 0, 0, 0, 4'd1, 0, 0, 0);
      st("t4_start1", 0, 4'd0, 1, 0, 0, 4'd1, 1, 0, 0);
      st("t4_ldterm", 1, 4'd9, 0, 0, 1, 4'd9, 0, 0, 1);

      // Full-range count from 15
      st("t6_load", 1, 4'd15, 0, 0, 0, 4'd15, 0, 0, 0);
      st("t6_start",0, 4'd0,  1, 0, 0, 4'd15, 1, 0, 0);
      for (int i = 1; i <= 15; i++) begin
         if (i < 15)
            st($sformatf("t6_tick%0d", i), 0, 4'd0, 0, 0, 1, 4'(15 - i), 1, 0, 0);
         else
            st("t6_tick15", 0, 4'd0, 0, 0, 1, AR ? 4'd15 : 4'd0, AR, 1, 1);
      end

`ifdef AUTO_RELOAD_EN
      // Periodic divider with reload 2
      st("t5_load",  1, 4'd2, 0, 0, 0, 4'd2, 0, 0, 0);
      st("t5_start", 0, 4'd0, 1, 0, 0, 4'd2, 1, 0, 0);
      for (int i = 1; i <= 6; i++) begin
         if (i % 2 == 1)
            st($sformatf("t5_tick%0d", i), 0, 4'd0, 0, 0, 1, 4'd1, 1, 0, 0);
         else
            st($sformatf("t5_tick%0d", i), 0, 4'd0, 0, 0, 1, 4'd2, 1, 1, 1);
      end
`endif

      // Async reset mid-run with cnt=5
      st("t1_load",  1, 4'd5, 0, 0, 0, 4'd5, 0, 0, 0);
      st("t1_start", 0, 4'd0, 1, 0, 0, 4'd5, 1, 0, 0);
      @(negedge clk);
      idle_inputs();
      #3;
      rstn = 1'b0;
      #1;
      chk("t1_rst.cnt",  32'(tif.cnt),  32'd0);
      chk("t1_rst.busy", 32'(tif.busy), 32'd0);
      chk("t1_rst.done", 32'(tif.done), 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Async reset while done is high clears it at once
      st("t1b_load",  1, 4'd1, 0, 0, 0, 4'd1, 0, 0, 0);
      st("t1b_start", 0, 4'd0, 1, 0, 0, 4'd1, 1, 0, 0);
      st("t1b_term",  0, 4'd0, 0, 0, 1, AR ? 4'd1 : 4'd0, AR, 1, 1);
      @(negedge clk);
      idle_inputs();
      #3;
      rstn = 1'b0;
      #1;
      chk("t1b_rst.done", 32'(tif.done), 32'd0);
      chk("t1b_rst.busy", 32'(tif.busy), 32'd0);
      chk("t1b_rst.cnt",  32'(tif.cnt),  32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      chk("drain.left", 32'(q.size()), 32'd0);
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
